// File: rtl/rv_pkg.sv
// Shared defaults and helpers for the integer register file and its scoreboard.
package rv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    WB_RESULT = 1'b0,
    WB_MEMORY = 1'b1
  } wb_src_e;

  function automatic int aw_of(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// Per-register write-pending bits; a new issue beats a same-cycle retirement.
// Stall is combinational; forwarded sources (clrN) never stall.
module rv_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS   = NREGS_DEF,
  parameter int AW      = aw_of(NREGS),
  parameter bit X0_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_vld_i,
  input  logic [AW-1:0]    iss_rd_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    rd_i,
  input  logic             rd_en1_i,
  input  logic [AW-1:0]    rs1_i,
  input  logic             clr1_i,
  input  logic             rd_en2_i,
  input  logic [AW-1:0]    rs2_i,
  input  logic             clr2_i,
  output logic             stall_o,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_en_i && (rd_i == AW'(i))) busy_d[i] = 1'b0;
      if (iss_vld_i && (iss_rd_i == AW'(i)) && !(X0_ZERO && (i == 0))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign stall_o = (rd_en1_i && busy_q[rs1_i] && !clr1_i) ||
                   (rd_en2_i && busy_q[rs2_i] && !clr2_i);
  assign busy_o  = busy_q;

endmodule

// File: rtl/rv_regfile_sb.sv
// Integer register file: two combinational reads with writeback bypass, a
// registered store-data read, and a scoreboard-driven hazard stall.
module rv_regfile_sb
  import rv_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int NREGS       = NREGS_DEF,
  parameter int AW          = aw_of(NREGS),
  parameter bit X0_ZERO     = 1'b1,
  parameter bit RESET_INDEX = 1'b1,
  parameter bit BYPASS      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en1,
  input  logic             rd_en2,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic [XLEN-1:0]  data1,
  output logic [XLEN-1:0]  data2,
  input  logic             st_req,
  output logic [XLEN-1:0]  data3,
  input  logic             iss_vld,
  input  logic [AW-1:0]    iss_rd,
  input  logic             wr_en,
  input  logic             load,
  input  logic [AW-1:0]    rd,
  input  logic [XLEN-1:0]  result,
  input  logic [XLEN-1:0]  memory,
  output logic             stall,
  output logic [NREGS-1:0] busy
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] data3_q, data3_d;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] raw1, raw2;
  logic            zero1, zero2, fwd1, fwd2;
  wb_src_e         wb_src;

  assign wb_src = wb_src_e'(load);
  assign wdata  = (wb_src == WB_MEMORY) ? memory : result;

  assign zero1 = X0_ZERO && (rs1 == '0);
  assign zero2 = X0_ZERO && (rs2 == '0);
  assign fwd1  = BYPASS && wr_en && (rd == rs1) && !zero1;
  assign fwd2  = BYPASS && wr_en && (rd == rs2) && !zero2;

  // Unqualified by rd_en: the store capture uses port 2 even when it is disabled.
  assign raw1 = zero1 ? '0 : (fwd1 ? wdata : regs_q[rs1]);
  assign raw2 = zero2 ? '0 : (fwd2 ? wdata : regs_q[rs2]);

  assign data1 = rd_en1 ? raw1 : '0;
  assign data2 = rd_en2 ? raw2 : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (RESET_INDEX && !(X0_ZERO && (i == 0))) ? XLEN'(i) : '0;
    end else if (wr_en && !(X0_ZERO && (rd == '0))) begin
      regs_q[rd] <= wdata;
    end
  end

  assign data3_d = st_req ? raw2 : data3_q;

  always_ff @(posedge clk) begin
    if (reset) data3_q <= '0;
    else       data3_q <= data3_d;
  end

  assign data3 = data3_q;

  rv_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .X0_ZERO(X0_ZERO)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_vld_i(iss_vld),
    .iss_rd_i (iss_rd),
    .wr_en_i  (wr_en),
    .rd_i     (rd),
    .rd_en1_i (rd_en1),
    .rs1_i    (rs1),
    .clr1_i   (fwd1),
    .rd_en2_i (rd_en2),
    .rs2_i    (rs2),
    .clr2_i   (fwd2),
    .stall_o  (stall),
    .busy_o   (busy)
  );

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Directed bench for rv_regfile_sb with hand-computed expectations.
module tb_rv_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en1, rd_en2;
  logic [4:0]  rs1, rs2;
  logic [31:0] data1, data2, data3;
  logic        st_req;
  logic        iss_vld;
  logic [4:0]  iss_rd;
  logic        wr_en, load;
  logic [4:0]  rd;
  logic [31:0] result, memory;
  logic        stall;
  logic [31:0] busy;

  int errs   = 0;
  int checks = 0;

  rv_regfile_sb dut (
    .clk    (clk),
    .reset  (reset),
    .rd_en1 (rd_en1),
    .rd_en2 (rd_en2),
    .rs1    (rs1),
    .rs2    (rs2),
    .data1  (data1),
    .data2  (data2),
    .st_req (st_req),
    .data3  (data3),
    .iss_vld(iss_vld),
    .iss_rd (iss_rd),
    .wr_en  (wr_en),
    .load   (load),
    .rd     (rd),
    .result (result),
    .memory (memory),
    .stall  (stall),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge, so they are stable well before the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; rd_en1 = 1'b0; rd_en2 = 1'b0; rs1 = '0; rs2 = '0;
    st_req = 1'b0; iss_vld = 1'b0; iss_rd = '0; wr_en = 1'b0; load = 1'b0;
    rd = '0; result = '0; memory = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset values
    rd_en1 = 1'b1; rd_en2 = 1'b1; rs1 = 5'd7; rs2 = 5'd31;
    #1;
    chk("rst_data1", data1, 32'd7);
    chk("rst_data2", data2, 32'd31);
    chk("rst_busy",  busy,  32'h0);
    chk("rst_data3", data3, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);

    // Load writeback with same-cycle bypass
    wr_en = 1'b1; load = 1'b1; rd = 5'd5; memory = 32'hDEADBEEF; result = 32'd1; rs1 = 5'd5;
    #1;
    chk("byp_load", data1, 32'hDEADBEEF);
    chk("byp_other_port", data2, 32'd31);
    tick();
    wr_en = 1'b0; load = 1'b0; rd_en1 = 1'b0;
    #1;
    chk("rden1_off", data1, 32'h0);
    rd_en1 = 1'b1;
    #1;
    chk("reg5_stored", data1, 32'hDEADBEEF);

    // x0 ignores writes and never becomes busy
    wr_en = 1'b1; rd = 5'd0; result = 32'h1234; rs1 = 5'd0;
    #1;
    chk("x0_no_bypass", data1, 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("x0_after_write", data1, 32'h0);
    iss_vld = 1'b1; iss_rd = 5'd0;
    tick();
    iss_vld = 1'b0;
    #1;
    chk("x0_not_busy", busy, 32'h0);

    // RAW stall resolved by forwarding
    iss_vld = 1'b1; iss_rd = 5'd3;
    tick();
    iss_vld = 1'b0; rs1 = 5'd3;
    #1;
    chk("busy3_set", busy, 32'h0000_0008);
    chk("stall_rs1", 32'(stall), 32'h1);
    wr_en = 1'b1; rd = 5'd3; result = 32'd9; load = 1'b0;
    #1;
    chk("stall_fwd", 32'(stall), 32'h0);
    chk("fwd_data1", data1, 32'd9);
    tick();
    wr_en = 1'b0;
    #1;
    chk("busy3_clear", busy, 32'h0);
    chk("reg3_stored", data1, 32'd9);

    // Stall gated by read enable on port 2
    iss_vld = 1'b1; iss_rd = 5'd10;
    tick();
    iss_vld = 1'b0; rs1 = 5'd7; rs2 = 5'd10; rd_en2 = 1'b0;
    #1;
    chk("stall_rden2_off", 32'(stall), 32'h0);
    rd_en2 = 1'b1;
    #1;
    chk("stall_rs2", 32'(stall), 32'h1);

    // Issue and writeback on the same register: set wins
    iss_vld = 1'b1; iss_rd = 5'd4; wr_en = 1'b1; rd = 5'd4; result = 32'd77; rs2 = 5'd31;
    tick();
    iss_vld = 1'b0; wr_en = 1'b0; rs1 = 5'd4;
    #1;
    chk("busy4_set_wins", busy, 32'h0000_0410);
    chk("reg4_written", data1, 32'd77);

    // Store capture uses bypassed port-2 value even with rd_en2 low
    rs2 = 5'd6; rd_en2 = 1'b0; st_req = 1'b1; wr_en = 1'b1; rd = 5'd6; result = 32'd42;
    tick();
    st_req = 1'b0; wr_en = 1'b0; rs2 = 5'd31;
    #1;
    chk("data3_bypass", data3, 32'd42);
    tick();
    chk("data3_hold", data3, 32'd42);

    // Mid-operation reset clears pending state and ignores side inputs
    iss_vld = 1'b1; iss_rd = 5'd8;
    tick();
    iss_vld = 1'b0;
    #1;
    chk("busy8_set", busy, 32'h0000_0510);
    reset = 1'b1; wr_en = 1'b1; rd = 5'd8; result = 32'd5; iss_vld = 1'b1; iss_rd = 5'd9;
    st_req = 1'b1;
    tick();
    reset = 1'b0; wr_en = 1'b0; iss_vld = 1'b0; st_req = 1'b0; rs1 = 5'd8; rs2 = 5'd4;
    rd_en2 = 1'b1;
    #1;
    chk("reset_busy", busy, 32'h0);
    chk("reset_reg8", data1, 32'd8);
    chk("reset_reg4", data2, 32'd4);
    chk("reset_data3", data3, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
